module_switch_reader: RTL and testbench



---
 rtl/switch_pkg.sv | 13 +
 rtl/sync_2ff.sv | 25 ++
 rtl/module_switch_reader.sv | 112 +++++++++++
 tb/tb_module_switch_reader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch input path and the decoder/LED chain.
package switch_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } deb_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Reset value is all-ones so that active-low pads read as "released".
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // First stage captures the raw pads, second stage filters metastability.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/module_switch_reader.sv
// Four active-low switch/button pads -> synchronized, debounced, positive-logic nibble
// with a one-cycle valid strobe on each accepted change.
// Build option: define DEBOUNCE_EN to enable the debounce FSM; without it the
// synchronized value is passed straight through (DEBOUNCE_CYCLES is then unused).
//
//   state       | meaning
//   ST_STABLE   | synchronized input matches binario, waiting for a change
//   ST_CHANGING | input differs from binario, counting how long cand holds
module module_switch_reader
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output nibble_t    binario,
  output logic       valid
);

  logic [3:0] s2;
  nibble_t    inv;

  sync_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw),
    .q    (s2)
  );

  // Pads are active-low; invert once here so everything downstream is positive logic.
  assign inv = ~s2;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  nibble_t          cand, cand_nxt;
  nibble_t          binario_nxt;
  logic             valid_nxt;

  // State, counter, candidate and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      cand    <= '0;
      binario <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cand    <= cand_nxt;
      binario <= binario_nxt;
      valid   <= valid_nxt;
    end
  end

  // Next-state: the whole nibble is debounced as one unit; any change of the
  // candidate restarts the count, a return to the committed value aborts.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    binario_nxt = binario;
    valid_nxt   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (inv != binario) begin
          state_nxt = ST_CHANGING;
          cand_nxt  = inv;
          cnt_nxt   = '0;
        end
      end
      ST_CHANGING: begin
        if (inv == binario) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (inv != cand) begin
          cand_nxt = inv;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          binario_nxt = cand;
          valid_nxt   = 1'b1;
          state_nxt   = ST_STABLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Pass-through: register the synchronized value and flag any difference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binario <= '0;
      valid   <= 1'b0;
    end else begin
      binario <= inv;
      valid   <= (inv != binario);
    end
  end
`endif

endmodule

// File: tb/tb_module_switch_reader.sv
// Self-checking bench for module_switch_reader (DEBOUNCE_CYCLES = 8).
// Expected commits (value and cycle) are queued when stimulus is driven and
// checked when the DUT pulses valid; between commits binario must hold.
module tb_module_switch_reader;
  import switch_pkg::*;

  localparam int N = 8;
`ifdef DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = N + 3;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 3;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw    = 4'b0000;
  nibble_t    binario;
  logic       valid;

  int      cyc    = 0;
  int      checks = 0;
  int      errors = 0;
  logic    rst_q  = 1'b0;
  nibble_t held   = '0;

  typedef struct {
    nibble_t val;
    int      due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] sw;
    int         hold;
    bit         deb_commit;
    bit         byp_commit;
  } vec_t;
  vec_t vecs[8];

  module_switch_reader #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .binario(binario),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, commits against the scoreboard, hold between commits.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_q) begin
      chk("reset_binario", 32'(binario), 32'(0));
      chk("reset_valid", 32'(valid), 32'(0));
      held = '0;
    end else if (valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid actual binario=%h expected no strobe cyc=%0d", binario, cyc);
      end else begin
        e = sbq.pop_front();
        held = e.val;
        chk("commit_value", 32'(binario), 32'(e.val));
        chk("commit_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("hold_value", 32'(binario), 32'(held));
      if (sbq.size() != 0 && cyc >= sbq[0].due) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_commit actual no valid expected value=%h at cyc=%0d", e.val, e.due);
      end
    end
  end

  task automatic drive(input logic [3:0] v, input int hold, input bit commit);
    @(posedge clk);
    #1;
    sw = v;
    if (commit) sbq.push_back('{nibble_t'(~v), cyc + LAT});
    repeat (hold - 1) @(posedge clk);
  endtask

  initial begin
    int c;
    vecs[0] = '{4'b1111, 14, 1'b1, 1'b1};  // release all -> 0000
    vecs[1] = '{4'b1010, 14, 1'b1, 1'b1};  // clean press -> 0101
    vecs[2] = '{4'b1111, 14, 1'b1, 1'b1};  // release -> 0000
    vecs[3] = '{4'b1110,  4, 1'b0, 1'b1};  // short bounce
    vecs[4] = '{4'b1111, 14, 1'b0, 1'b1};  // back to committed value
    vecs[5] = '{4'b1110,  5, 1'b0, 1'b1};  // first bit of a two-bit press
    vecs[6] = '{4'b1100, 14, 1'b1, 1'b1};  // settled vector -> 0011
    vecs[7] = '{4'b0111, 14, 1'b1, 1'b1};  // -> 1000

    // Reset held with all pads pressed; they commit after release.
    rst_n = 1'b0;
    sw    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.push_back('{4'b1111, cyc + LAT});
    repeat (LAT + 3) @(posedge clk);

    for (int i = 0; i < 8; i++)
      drive(vecs[i].sw, vecs[i].hold, DEB ? vecs[i].deb_commit : vecs[i].byp_commit);

    // Reset lands on the 6th edge after a change; debounce restarts from scratch.
    @(posedge clk);
    #1;
    sw = 4'b0000;
    c  = cyc;
    if (!DEB) sbq.push_back('{4'b1111, c + LAT});
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.push_back('{4'b1111, cyc + LAT});
    repeat (LAT + 6) @(posedge clk);

    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_commits actual=%0d expected=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
